// File: rtl/multicycle_control.sv
// Multicycle control FSM for an RV32I subset (R-type, LW, SW, BEQ/BNE) sharing one memory port.
// Sequences PC/IR/ALU/regfile/memory enables; memory handshake guarded by a timeout watchdog.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_WB_R      = 4'd7,
        S_WB_LOAD   = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       in_mem_state;
    logic       timed_out;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    function automatic state_t dispatch(input logic [6:0] op, input logic [2:0] f3);
        state_t nxt;
        case (op)
            OP_RTYPE:           nxt = S_EXEC_R;
            OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
            OP_BRANCH:          nxt = (f3 == 3'b000 || f3 == 3'b001) ? S_BRANCH : S_TRAP;
            default:            nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // The watchdog fires on the last allowed waiting cycle; a ready in that cycle still completes.
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timed_out    = in_mem_state && !mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_TRAP;
            end
            S_DECODE:    state_d = dispatch(opcode, funct3);
            S_EXEC_R:    state_d = S_WB_R;
            S_WB_R:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready)      state_d = S_WB_LOAD;
                else if (timed_out) state_d = S_TRAP;
            end
            S_MEM_WRITE: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timed_out) state_d = S_TRAP;
            end
            S_WB_LOAD:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Counter runs only while a request is stalled in place; any state change or completion clears it.
    always_comb begin
        cnt_d = '0;
        if (in_mem_state && !mem_ready && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        trap_d  = trap_q;
        cause_d = cause_q;
        if (!trap_q && (state_d == S_TRAP) && (state_q != S_TRAP)) begin
            trap_d  = 1'b1;
            cause_d = (state_q == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
            end
            S_WB_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            // funct3 bit 0 distinguishes BNE from BEQ; other funct3 values never reach here.
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = funct3[0] ? ~zero : zero;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction cycle-sequence model.
module tb_multicycle_control;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_req, mem_we, iord;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        pc_src, reg_write, mem_to_reg, retire, trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    int checks = 0;
    int failures = 0;
    logic [21:0] exp_q[$];
    bit          rdy_q[$];
    logic [21:0] cur_exp;

    // Field order: state, pcw, irw, req, we, iord, asa, asb, aop, pcs, rw, m2r, ret, trap, cause.
    // f = {pcw, irw, req, we, iord, pcs, rw, m2r, ret}
    function automatic logic [21:0] ev(input logic [3:0] st, input logic [1:0] asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [8:0] f, input logic [1:0] cause);
        return {st, f[8], f[7], f[6], f[5], f[4], asa, asb, aop, f[3], f[2], f[1], f[0],
                (st == 4'd15), cause};
    endfunction

    function automatic logic [21:0] obs();
        return {state, pc_write, ir_write, mem_req, mem_we, iord, alu_src_a, alu_src_b, alu_op,
                pc_src, reg_write, mem_to_reg, retire, trap, trap_cause};
    endfunction

    function automatic bit rbit();
        return ($urandom & 32'd1) != 0;
    endfunction

    task automatic push(input logic [21:0] e, input bit r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // A memory phase: 'waits' stalled cycles then one completing cycle, or a timeout after TIMEOUT stalls.
    task automatic model_mem(input logic [21:0] wait_v, input logic [21:0] done_v,
                             input int waits, output bit timed);
        timed = (waits >= TIMEOUT);
        for (int i = 0; i < (timed ? TIMEOUT : waits); i++) push(wait_v, 1'b0);
        if (!timed) push(done_v, 1'b1);
    endtask

    task automatic model_trap(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) push(ev(4'd15, 2'b00, 2'b00, 2'b00, 9'b0, cause), rbit());
    endtask

    task automatic model_instr(input logic [31:0] ins, input int fw, input int mw,
                               input bit z, output bit trapped);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        bit t;
        trapped = 1'b0;
        model_mem(ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b001000000, 2'b00),
                  ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b111000000, 2'b00), fw, t);
        if (t) begin
            model_trap(2'b10);
            trapped = 1'b1;
            return;
        end
        push(ev(4'd2, 2'b10, 2'b10, 2'b00, 9'b0, 2'b00), rbit());
        if (op == 7'b0110011) begin
            push(ev(4'd3, 2'b01, 2'b00, 2'b10, 9'b0, 2'b00), rbit());
            push(ev(4'd7, 2'b00, 2'b00, 2'b00, 9'b000000101, 2'b00), rbit());
        end else if (op == 7'b0000011) begin
            push(ev(4'd4, 2'b01, 2'b10, 2'b00, 9'b0, 2'b00), rbit());
            model_mem(ev(4'd5, 2'b00, 2'b00, 2'b00, 9'b001010000, 2'b00),
                      ev(4'd5, 2'b00, 2'b00, 2'b00, 9'b001010000, 2'b00), mw, t);
            if (t) begin
                model_trap(2'b10);
                trapped = 1'b1;
            end else begin
                push(ev(4'd8, 2'b00, 2'b00, 2'b00, 9'b000000111, 2'b00), rbit());
            end
        end else if (op == 7'b0100011) begin
            push(ev(4'd4, 2'b01, 2'b10, 2'b00, 9'b0, 2'b00), rbit());
            model_mem(ev(4'd6, 2'b00, 2'b00, 2'b00, 9'b001110000, 2'b00),
                      ev(4'd6, 2'b00, 2'b00, 2'b00, 9'b001110001, 2'b00), mw, t);
            if (t) begin
                model_trap(2'b10);
                trapped = 1'b1;
            end
        end else if (op == 7'b1100011 && f3 <= 3'd1) begin
            push(ev(4'd9, 2'b01, 2'b00, 2'b01,
                    {((f3 == 3'd0) ? z : !z), 8'b00001001}, 2'b00), rbit());
        end else begin
            model_trap(2'b01);
            trapped = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_next();
        cur_exp   = exp_q.pop_front();
        mem_ready = rdy_q.pop_front();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        instr = 32'h002081B3;
        mem_ready = 1'b1;
        zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs() !== 22'h0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs(), 22'h0);
            end
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs() !== 22'h0) begin
            failures++;
            $display("FAIL reset_idle got=%h want=%h", obs(), 22'h0);
        end
        tick();
        #1;
        checks++;
        if (obs() !== ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b001000000, 2'b00)) begin
            failures++;
            $display("FAIL reset_first_fetch got=%h want=%h", obs(),
                     ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b001000000, 2'b00));
        end
    endtask

    task automatic test_rtype();
        bit t;
        int n = 0;
        instr = 32'h002081B3;
        model_instr(instr, 0, 0, zero, t);
        while (exp_q.size() != 0) begin
            apply_next();
            checks++;
            if (obs() !== cur_exp) begin
                failures++;
                $display("FAIL rtype cyc=%0d got=%h want=%h", n, obs(), cur_exp);
            end
            tick();
            n++;
        end
    endtask

    task automatic test_load_wait();
        bit t;
        int n = 0;
        instr = 32'h0080A283;
        model_instr(instr, 0, 3, zero, t);
        while (exp_q.size() != 0) begin
            apply_next();
            checks++;
            if (obs() !== cur_exp) begin
                failures++;
                $display("FAIL load_wait cyc=%0d got=%h want=%h", n, obs(), cur_exp);
            end
            tick();
            n++;
        end
    endtask

    task automatic test_store();
        bit t;
        int n = 0;
        instr = 32'h0050A623;
        model_instr(instr, 1, 2, zero, t);
        while (exp_q.size() != 0) begin
            apply_next();
            checks++;
            if (obs() !== cur_exp || reg_write !== 1'b0) begin
                failures++;
                $display("FAIL store cyc=%0d got=%h want=%h", n, obs(), cur_exp);
            end
            tick();
            n++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] br[4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
        bit          zv[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit t;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            instr = br[k];
            zero = zv[k];
            model_instr(instr, k, 0, zero, t);
            while (exp_q.size() != 0) begin
                apply_next();
                checks++;
                if (obs() !== cur_exp) begin
                    failures++;
                    $display("FAIL branch%0d cyc=%0d got=%h want=%h", k, n, obs(), cur_exp);
                end
                tick();
                n++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad[2] = '{32'h00000000, 32'h0020A463};
        bit t;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            instr = bad[k];
            model_instr(instr, 0, 0, zero, t);
            while (exp_q.size() != 0) begin
                apply_next();
                checks++;
                if (obs() !== cur_exp) begin
                    failures++;
                    $display("FAIL illegal%0d cyc=%0d got=%h want=%h", k, n, obs(), cur_exp);
                end
                tick();
                n++;
            end
            rst_n = 1'b0;
            tick();
            checks++;
            if (obs() !== 22'h0) begin
                failures++;
                $display("FAIL trap_clear%0d got=%h want=%h", k, obs(), 22'h0);
            end
            rst_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_timeouts();
        logic [31:0] ins[3] = '{32'h002081B3, 32'h0080A283, 32'h0050A623};
        int          fw[3]  = '{TIMEOUT, 0, 2};
        int          mw[3]  = '{0, TIMEOUT, TIMEOUT};
        bit t;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            instr = ins[k];
            model_instr(instr, fw[k], mw[k], zero, t);
            while (exp_q.size() != 0) begin
                apply_next();
                checks++;
                if (obs() !== cur_exp) begin
                    failures++;
                    $display("FAIL timeout%0d cyc=%0d got=%h want=%h", k, n, obs(), cur_exp);
                end
                tick();
                n++;
            end
            do_reset();
        end
    endtask

    task automatic test_ready_boundary();
        logic [31:0] ins[2] = '{32'h0080A283, 32'h0050A623};
        bit t;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            instr = ins[k];
            model_instr(instr, TIMEOUT - 1, TIMEOUT - 1, zero, t);
            while (exp_q.size() != 0) begin
                apply_next();
                checks++;
                if (obs() !== cur_exp) begin
                    failures++;
                    $display("FAIL boundary%0d cyc=%0d got=%h want=%h", k, n, obs(), cur_exp);
                end
                tick();
                n++;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  op;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0000011;
            2: r[6:0] = 7'b0100011;
            3: begin
                r[6:0] = 7'b1100011;
                r[14:12] = 3'($urandom_range(0, 1));
            end
            4: begin
                r[6:0] = 7'b1100011;
                r[14:12] = 3'($urandom_range(2, 7));
            end
            default: begin
                op = 7'($urandom);
                if (op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011)
                    op = 7'b0010011;
                r[6:0] = op;
            end
        endcase
        return r;
    endfunction

    task automatic test_random();
        bit t;
        for (int k = 0; k < 40; k++) begin
            int n = 0;
            int fw = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            int mw = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            instr = rand_instr();
            zero = rbit();
            model_instr(instr, fw, mw, zero, t);
            while (exp_q.size() != 0) begin
                apply_next();
                checks++;
                if (obs() !== cur_exp) begin
                    failures++;
                    $display("FAIL random%0d instr=%h cyc=%0d got=%h want=%h", k, instr, n, obs(), cur_exp);
                end
                tick();
                n++;
            end
            if (t) do_reset();
        end
    endtask

    task automatic test_reset_abort();
        bit t;
        int n = 0;
        instr = 32'h0080A283;
        model_instr(instr, 0, TIMEOUT, zero, t);
        while (n < 6) begin
            apply_next();
            checks++;
            if (obs() !== cur_exp) begin
                failures++;
                $display("FAIL abort_pre cyc=%0d got=%h want=%h", n, obs(), cur_exp);
            end
            tick();
            n++;
        end
        exp_q.delete();
        rdy_q.delete();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (obs() !== 22'h0) begin
            failures++;
            $display("FAIL abort_idle got=%h want=%h", obs(), 22'h0);
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        tick();
        #1;
        checks++;
        if (obs() !== ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b001000000, 2'b00)) begin
            failures++;
            $display("FAIL abort_refetch got=%h want=%h", obs(),
                     ev(4'd1, 2'b00, 2'b01, 2'b00, 9'b001000000, 2'b00));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_illegal();
        test_timeouts();
        test_ready_boundary();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
